// File: rtl/io_bus_arbiter_if.sv
// Requester-side and IO-port-side signal bundle for io_bus_arbiter.
// The arbiter uses the slave view; the master view drives requests and IO read data.
interface io_bus_arbiter_if;
  logic        m0_req;
  logic        m1_req;
  logic        m0_we;
  logic        m1_we;
  logic [1:0]  m0_addr;
  logic [1:0]  m1_addr;
  logic [11:0] m0_wdata;
  logic [11:0] m1_wdata;
  logic        m0_ack;
  logic        m1_ack;
  logic [31:0] m0_rdata;
  logic [31:0] m1_rdata;
  logic        io_read;
  logic        io_write;
  logic [1:0]  io_addr;
  logic [11:0] io_wdata;
  logic [31:0] io_rdata;

  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata, io_rdata,
    output m0_ack, m1_ack, m0_rdata, m1_rdata, io_read, io_write, io_addr, io_wdata
  );

  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata, io_rdata,
    input  m0_ack, m1_ack, m0_rdata, m1_rdata, io_read, io_write, io_addr, io_wdata
  );
endinterface

// File: rtl/io_bus_arbiter.sv
// Two-requester arbiter sharing one IO register port; each transaction runs
// IDLE -> ACCESS (single io strobe) -> RESP (single ack), in round-robin or fixed-priority mode.
module io_bus_arbiter #(
  parameter int PRIO_MODE    = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  io_bus_arbiter_if.slave   bus,
  output logic              busy,
  output logic              grant_id
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state_reg, state_next;
  logic        grant_id_reg;
  logic        last_grant_reg;
  logic [3:0]  cnt_reg;
  logic        we_reg;
  logic [1:0]  addr_reg;
  logic [11:0] wdata_reg;
  logic [31:0] rdata_reg [0:1];
  logic        any_req;
  logic        grant;
  logic        winner;

  assign any_req = bus.m0_req | bus.m1_req;
  assign grant   = (state_reg == IDLE) && any_req;

  // Tie-break: alternate in round-robin; in fixed mode m0 wins until the starve counter saturates.
  always_comb begin
    winner = 1'b0;
    if (bus.m0_req && bus.m1_req) begin
      if (PRIO_MODE == 0)
        winner = ~last_grant_reg;
      else
        winner = (cnt_reg == LIMIT);
    end else if (bus.m1_req) begin
      winner = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      grant_id_reg   <= 1'b0;
      last_grant_reg <= 1'b1;
      cnt_reg        <= 4'd0;
      we_reg         <= 1'b0;
      addr_reg       <= 2'd0;
      wdata_reg      <= 12'd0;
      for (int i = 0; i < 2; i++)
        rdata_reg[i] <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (grant) begin
        grant_id_reg   <= winner;
        last_grant_reg <= winner;
        we_reg         <= winner ? bus.m1_we    : bus.m0_we;
        addr_reg       <= winner ? bus.m1_addr  : bus.m0_addr;
        wdata_reg      <= winner ? bus.m1_wdata : bus.m0_wdata;
        if (winner)
          cnt_reg <= 4'd0;
        else if (cnt_reg != LIMIT)
          cnt_reg <= cnt_reg + 4'd1;
      end
      if (state_reg == ACCESS && !we_reg)
        rdata_reg[grant_id_reg] <= bus.io_rdata;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bus.io_read  = 1'b0;
    bus.io_write = 1'b0;
    bus.io_addr  = 2'd0;
    bus.io_wdata = 12'd0;
    bus.m0_ack   = 1'b0;
    bus.m1_ack   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any_req)
          state_next = ACCESS;
      end
      ACCESS: begin
        state_next   = RESP;
        bus.io_read  = ~we_reg;
        bus.io_write = we_reg;
        bus.io_addr  = addr_reg;
        bus.io_wdata = wdata_reg;
      end
      RESP: begin
        state_next = IDLE;
        bus.m0_ack = ~grant_id_reg;
        bus.m1_ack = grant_id_reg;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.m0_rdata = rdata_reg[0];
  assign bus.m1_rdata = rdata_reg[1];
  assign busy         = (state_reg != IDLE);
  assign grant_id     = grant_id_reg;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench: a round-robin instance and a fixed-priority (limit 2) instance,
// with per-cycle protocol monitoring on both.
module tb_io_bus_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy_rr, gid_rr, busy_fx, gid_fx;
  int   checks = 0;
  int   fails  = 0;
  logic prev_acc_rr = 1'b0;
  logic prev_acc_fx = 1'b0;

  always #5 clk = ~clk;

  io_bus_arbiter_if bus_rr();
  io_bus_arbiter_if bus_fx();

  io_bus_arbiter #(.PRIO_MODE(0), .STARVE_LIMIT(4)) dut_rr (
    .clk(clk), .reset(reset), .bus(bus_rr), .busy(busy_rr), .grant_id(gid_rr));

  io_bus_arbiter #(.PRIO_MODE(1), .STARVE_LIMIT(2)) dut_fx (
    .clk(clk), .reset(reset), .bus(bus_fx), .busy(busy_fx), .grant_id(gid_fx));

  // Every cycle: no simultaneous strobes, and any ack must follow an access by the same grant.
  always @(negedge clk) begin
    checks++;
    if ((bus_rr.io_read && bus_rr.io_write) || (bus_fx.io_read && bus_fx.io_write)) begin
      fails++;
      $display("FAIL mon_strobes: rr=%b%b fx=%b%b required not both high",
               bus_rr.io_read, bus_rr.io_write, bus_fx.io_read, bus_fx.io_write);
    end
    if (bus_rr.m0_ack || bus_rr.m1_ack) begin
      checks++;
      if (!prev_acc_rr || (bus_rr.m0_ack && bus_rr.m1_ack) || (bus_rr.m1_ack !== gid_rr)) begin
        fails++;
        $display("FAIL mon_ack_rr: acks=%b%b prev_access=%b gid=%b required prior grant",
                 bus_rr.m1_ack, bus_rr.m0_ack, prev_acc_rr, gid_rr);
      end
    end
    if (bus_fx.m0_ack || bus_fx.m1_ack) begin
      checks++;
      if (!prev_acc_fx || (bus_fx.m0_ack && bus_fx.m1_ack) || (bus_fx.m1_ack !== gid_fx)) begin
        fails++;
        $display("FAIL mon_ack_fx: acks=%b%b prev_access=%b gid=%b required prior grant",
                 bus_fx.m1_ack, bus_fx.m0_ack, prev_acc_fx, gid_fx);
      end
    end
    prev_acc_rr = bus_rr.io_read | bus_rr.io_write;
    prev_acc_fx = bus_fx.io_read | bus_fx.io_write;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus_rr.m0_req = 0; bus_rr.m1_req = 0; bus_rr.m0_we = 0; bus_rr.m1_we = 0;
    bus_rr.m0_addr = 0; bus_rr.m1_addr = 0; bus_rr.m0_wdata = 0; bus_rr.m1_wdata = 0;
    bus_rr.io_rdata = 32'hFFFF_FFFF;
    bus_fx.m0_req = 0; bus_fx.m1_req = 0; bus_fx.m0_we = 0; bus_fx.m1_we = 0;
    bus_fx.m0_addr = 0; bus_fx.m1_addr = 0; bus_fx.m0_wdata = 0; bus_fx.m1_wdata = 0;
    bus_fx.io_rdata = 32'hFFFF_FFFF;
    reset = 1;
    tick; tick;
    checks++;
    if ({busy_rr, gid_rr, bus_rr.m0_ack, bus_rr.m1_ack, bus_rr.io_read, bus_rr.io_write,
         bus_rr.io_addr, bus_rr.io_wdata} !== 19'd0) begin
      fails++;
      $display("FAIL reset_outputs_rr: got %h required 0", {busy_rr, gid_rr, bus_rr.m0_ack,
               bus_rr.m1_ack, bus_rr.io_read, bus_rr.io_write, bus_rr.io_addr, bus_rr.io_wdata});
    end
    checks++;
    if ({bus_rr.m0_rdata, bus_rr.m1_rdata, bus_fx.m0_rdata, bus_fx.m1_rdata} !== 128'd0) begin
      fails++;
      $display("FAIL reset_rdata: got %h %h required 0", bus_rr.m0_rdata, bus_rr.m1_rdata);
    end
    reset = 0;
    tick;
    checks++;
    if ({busy_rr, busy_fx, gid_rr, gid_fx} !== 4'd0) begin
      fails++;
      $display("FAIL reset_idle: got busy=%b%b gid=%b%b required 0", busy_rr, busy_fx, gid_rr, gid_fx);
    end
  endtask

  task automatic test_single_read;
    bus_rr.m0_we = 0; bus_rr.m0_addr = 2'b10; bus_rr.m0_wdata = 0;
    bus_rr.io_rdata = 32'h0000_00A5; bus_rr.m0_req = 1;
    tick;  // ACCESS
    checks++;
    if ({bus_rr.io_read, bus_rr.io_write, bus_rr.io_addr, busy_rr, gid_rr} !== 6'b10_10_1_0) begin
      fails++;
      $display("FAIL read_access: got rd=%b wr=%b addr=%0d busy=%b gid=%b required 1 0 2 1 0",
               bus_rr.io_read, bus_rr.io_write, bus_rr.io_addr, busy_rr, gid_rr);
    end
    tick;  // RESP
    checks++;
    if ({bus_rr.m0_ack, bus_rr.m1_ack, bus_rr.io_read} !== 3'b100 || bus_rr.m0_rdata !== 32'hA5) begin
      fails++;
      $display("FAIL read_resp: got ack=%b%b rd=%b rdata=%h required 10 0 000000a5",
               bus_rr.m0_ack, bus_rr.m1_ack, bus_rr.io_read, bus_rr.m0_rdata);
    end
    bus_rr.m0_req = 0; bus_rr.io_rdata = 32'h1234_5678;
    tick;  // IDLE
    checks++;
    if ({busy_rr, bus_rr.m0_ack} !== 2'b00 || bus_rr.m0_rdata !== 32'hA5) begin
      fails++;
      $display("FAIL read_hold: got busy=%b ack=%b rdata=%h required 0 0 000000a5",
               busy_rr, bus_rr.m0_ack, bus_rr.m0_rdata);
    end
  endtask

  task automatic test_single_write;
    bus_rr.m1_we = 1; bus_rr.m1_addr = 2'd1; bus_rr.m1_wdata = 12'hABC; bus_rr.m1_req = 1;
    tick;  // ACCESS; inputs changed here must be ignored
    bus_rr.m1_addr = 2'd3; bus_rr.m1_wdata = 12'h000; bus_rr.m1_we = 0;
    #1;
    checks++;
    if ({bus_rr.io_read, bus_rr.io_write, bus_rr.io_addr, bus_rr.io_wdata, gid_rr} !== {2'b01, 2'd1, 12'hABC, 1'b1}) begin
      fails++;
      $display("FAIL write_access: got rd=%b wr=%b addr=%0d wdata=%h gid=%b required 0 1 1 abc 1",
               bus_rr.io_read, bus_rr.io_write, bus_rr.io_addr, bus_rr.io_wdata, gid_rr);
    end
    tick;  // RESP
    checks++;
    if ({bus_rr.m1_ack, bus_rr.m0_ack} !== 2'b10 || bus_rr.m1_rdata !== 32'd0 || bus_rr.m0_rdata !== 32'hA5) begin
      fails++;
      $display("FAIL write_resp: got ack=%b%b m1_rdata=%h m0_rdata=%h required 10 0 a5",
               bus_rr.m1_ack, bus_rr.m0_ack, bus_rr.m1_rdata, bus_rr.m0_rdata);
    end
    bus_rr.m1_req = 0;
    tick;
    checks++;
    if (busy_rr !== 1'b0 || gid_rr !== 1'b1) begin
      fails++;
      $display("FAIL write_idle: got busy=%b gid=%b required 0 1", busy_rr, gid_rr);
    end
  endtask

  task automatic test_back_to_back_rr;
    logic exp;
    int   cyc;
    cyc = 0;
    bus_rr.m0_we = 0; bus_rr.m0_addr = 2'd0; bus_rr.m1_we = 0; bus_rr.m1_addr = 2'd3;
    bus_rr.m0_req = 1; bus_rr.m1_req = 1;
    for (int k = 0; k < 4; k++) begin
      exp = k[0];
      bus_rr.io_rdata = 32'hC0DE_0000 + k;
      tick; cyc++;  // ACCESS
      checks++;
      if (gid_rr !== exp || bus_rr.io_addr !== (exp ? 2'd3 : 2'd0)) begin
        fails++;
        $display("FAIL rr_grant%0d: got gid=%b addr=%0d required gid=%b", k, gid_rr, bus_rr.io_addr, exp);
      end
      tick; cyc++;  // RESP
      checks++;
      if ({bus_rr.m1_ack, bus_rr.m0_ack} !== (exp ? 2'b10 : 2'b01)) begin
        fails++;
        $display("FAIL rr_ack%0d: cycle %0d got acks=%b%b required owner %b", k, cyc,
                 bus_rr.m1_ack, bus_rr.m0_ack, exp);
      end
      checks++;
      if ((exp ? bus_rr.m1_rdata : bus_rr.m0_rdata) !== 32'hC0DE_0000 + k) begin
        fails++;
        $display("FAIL rr_rdata%0d: got %h required %h", k,
                 exp ? bus_rr.m1_rdata : bus_rr.m0_rdata, 32'hC0DE_0000 + k);
      end
      tick; cyc++;  // IDLE
      if (k == 3) begin
        bus_rr.m0_req = 0; bus_rr.m1_req = 0;
      end
    end
    tick;
    checks++;
    if (busy_rr !== 1'b0) begin
      fails++;
      $display("FAIL rr_drain: got busy=%b required 0", busy_rr);
    end
  endtask

  task automatic test_fixed_starve;
    logic exp_seq [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    bus_fx.m0_we = 1; bus_fx.m0_wdata = 12'h111; bus_fx.m1_we = 1; bus_fx.m1_wdata = 12'h222;
    bus_fx.m0_req = 1; bus_fx.m1_req = 1;
    for (int k = 0; k < 6; k++) begin
      tick;  // ACCESS
      checks++;
      if (gid_fx !== exp_seq[k] || bus_fx.io_wdata !== (exp_seq[k] ? 12'h222 : 12'h111)) begin
        fails++;
        $display("FAIL fx_grant%0d: got gid=%b wdata=%h required gid=%b", k, gid_fx, bus_fx.io_wdata, exp_seq[k]);
      end
      tick;  // RESP
      checks++;
      if ({bus_fx.m1_ack, bus_fx.m0_ack} !== (exp_seq[k] ? 2'b10 : 2'b01)) begin
        fails++;
        $display("FAIL fx_ack%0d: got acks=%b%b required owner %b", k, bus_fx.m1_ack, bus_fx.m0_ack, exp_seq[k]);
      end
      tick;  // IDLE
      if (k == 5) begin
        bus_fx.m0_req = 0; bus_fx.m1_req = 0;
      end
    end
  endtask

  task automatic test_reset_abort;
    bus_rr.m0_we = 0; bus_rr.m0_addr = 2'd1; bus_rr.io_rdata = 32'h0000_0055; bus_rr.m0_req = 1;
    tick;  // ACCESS
    checks++;
    if (bus_rr.io_read !== 1'b1) begin
      fails++;
      $display("FAIL abort_access: got rd=%b required 1", bus_rr.io_read);
    end
    reset = 1; bus_rr.m0_req = 0;
    tick;
    checks++;
    if ({bus_rr.m0_ack, bus_rr.m1_ack, bus_rr.io_read, bus_rr.io_write, busy_rr, gid_rr} !== 6'd0
        || bus_rr.m0_rdata !== 32'd0) begin
      fails++;
      $display("FAIL abort_state: got ack=%b%b rd=%b wr=%b busy=%b gid=%b m0_rdata=%h required all 0",
               bus_rr.m0_ack, bus_rr.m1_ack, bus_rr.io_read, bus_rr.io_write, busy_rr, gid_rr, bus_rr.m0_rdata);
    end
    reset = 0;
    bus_rr.m1_we = 0; bus_rr.m1_addr = 2'd2; bus_rr.io_rdata = 32'hDEAD_BEEF; bus_rr.m1_req = 1;
    tick;  // ACCESS
    checks++;
    if ({bus_rr.io_read, bus_rr.io_addr, gid_rr} !== {1'b1, 2'd2, 1'b1}) begin
      fails++;
      $display("FAIL abort_next_access: got rd=%b addr=%0d gid=%b required 1 2 1",
               bus_rr.io_read, bus_rr.io_addr, gid_rr);
    end
    tick;  // RESP
    checks++;
    if ({bus_rr.m1_ack, bus_rr.m0_ack} !== 2'b10 || bus_rr.m1_rdata !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL abort_next_resp: got ack=%b%b rdata=%h required 10 deadbeef",
               bus_rr.m1_ack, bus_rr.m0_ack, bus_rr.m1_rdata);
    end
    bus_rr.m1_req = 0;
    tick;
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_single_write;
    test_back_to_back_rr;
    test_fixed_starve;
    test_reset_abort;
    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/io_bus_arbiter.md
IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

Interface
REQ-001 SHALL have parameter PRIO_MODE, default 0, meaning 0 = round-robin, 1 = fixed priority to m0.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum number of consecutive m0 grants in fixed mode while m1 is pending (legal range 1-15).
REQ-003 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports m0_req/m1_req  input  1  transaction request, held until the matching ack.
REQ-006 SHALL have ports m0_we/m1_we  input  1  1 = write, 0 = read.
REQ-007 SHALL have ports m0_addr/m1_addr  input  2  IO register address.
REQ-008 SHALL have ports m0_wdata/m1_wdata  input  12  write data.
REQ-009 SHALL have ports m0_ack/m1_ack  output  1  one-cycle completion pulse.
REQ-010 SHALL have ports m0_rdata/m1_rdata  output  32  read result, valid from the ack cycle onward.
REQ-011 SHALL have ports io_read/io_write  output  1  IO port strobes.
REQ-012 SHALL have port io_addr  output  2  IO port address.
REQ-013 SHALL have port io_wdata  output  12  IO port write data.
REQ-014 SHALL have port io_rdata  input  32  IO port combinational read data.
REQ-015 SHALL have port busy  output  1  high when state != IDLE.
REQ-016 SHALL have port grant_id  output  1  requester owning the current/last transaction.

Function
REQ-017 SHALL implement FSM states IDLE, ACCESS, RESP; transitions: IDLE->ACCESS on any req, ACCESS->RESP always, RESP->IDLE always.
REQ-018 In IDLE with a req, SHALL latch the winner's we/addr/wdata and the winner id on the clock edge; requester inputs SHALL be ignored outside IDLE.
REQ-019 In ACCESS, SHALL drive exactly one of io_read (we=0) or io_write (we=1) for one cycle, with io_addr/io_wdata taken from latched values.
REQ-020 Outside ACCESS, io_read, io_write, io_addr and io_wdata SHALL all be 0.
REQ-021 On a read in ACCESS, SHALL capture io_rdata into the winner's rdata register; a write SHALL leave that register unchanged.
REQ-022 In RESP, SHALL assert the winner's ack for exactly one cycle; the other ack SHALL stay 0.
REQ-023 Latency: req sampled in IDLE at cycle N -> io strobe at N+1 -> ack at N+2; back-to-back throughput SHALL be one transaction per 3 cycles.
REQ-024 A req still high in the cycle after its ack SHALL be treated as a new transaction.
REQ-025 Round-robin mode: a single requester SHALL win; on a tie, the requester that did not own the last grant SHALL win; the last-grant register SHALL be 1 after reset so that m0 wins the first tie.
REQ-026 Fixed mode: m0 SHALL win ties, except when the consecutive-m0-grant counter equals STARVE_LIMIT and m1_req=1, in which case m1 SHALL win.
REQ-027 The consecutive counter SHALL increment on each m0 grant, saturate at STARVE_LIMIT, and clear on any m1 grant.
REQ-028 grant_id SHALL update on the IDLE->ACCESS edge and hold until the next grant.
REQ-029 mX_rdata SHALL hold its value until the next read ack to the same requester.

Reset
REQ-030 On reset, SHALL force state=IDLE, busy=0, grant_id=0, acks=0, io strobes/addr/wdata=0, both rdata=0, last-grant=1, counter=0.
REQ-031 Reset asserted in ACCESS or RESP SHALL abort the transaction: no ack issued and no io strobe in the following cycle.
REQ-032 Reset SHALL take priority over every other event in the same cycle.

Verification
REQ-033 Single read: m0 read addr=2'b10, io_rdata=32'h0000_00A5 -> io_read high at N+1 with io_addr=2, m0_ack at N+2, m0_rdata=32'hA5.
REQ-034 Single write: m1 write addr=1, wdata=12'hABC -> io_write at N+1 with io_wdata=12'hABC, m1_ack at N+2, m1_rdata unchanged.
REQ-035 Round-robin contention: both reqs held for 4 transactions -> grants m0,m1,m0,m1 with acks at cycles 2,5,8,11.
REQ-036 Fixed mode, STARVE_LIMIT=2, both reqs held -> grants m0,m0,m1,m0,m0,m1.
REQ-037 Reset in ACCESS cycle -> no ack, io strobes 0 next cycle, busy=0; a following m1 read completes normally at +2.
REQ-038 Bench SHALL check every cycle that io_read and io_write are never both high and that no ack occurs without a prior grant.
